led_pwm_regs: RTL and testbench



---
 rtl/led_pwm_regs.sv | 139 +++++++++++++
 tb/tb_led_pwm_regs.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_regs.sv
// Register bank and PWM engine behind the AXI4-Lite slave's local bus.
// Per-channel duty/shadow/output logic lives in led_pwm_chan, instantiated once per LED.

module led_pwm_chan (
  input  logic       axi_clk,
  input  logic       axi_rstn,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  input  logic       i_load,
  input  logic       i_en,
  input  logic       i_inv,
  input  logic [7:0] i_pwm_cnt,
  output logic [7:0] o_duty,
  output logic       o_led
);
  logic [7:0] r_duty;
  logic [7:0] r_duty_act;
  logic       r_led;

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_duty     <= '0;
      r_duty_act <= '0;
      r_led      <= 1'b0;
    end else begin
      if (i_wr)   r_duty     <= i_wr_data;
      // Shadow copy takes the pre-write value when a write lands on a wrap.
      if (i_load) r_duty_act <= r_duty;
      r_led <= i_en ? ((i_pwm_cnt < r_duty_act) ^ i_inv) : i_inv;
    end
  end

  assign o_duty = r_duty;
  assign o_led  = r_led;
endmodule

module led_pwm_regs #(
  parameter int G_NUM_LEDS        = 8,
  parameter int G_BASE_ADDR_WIDTH = 13
) (
  input  logic                         axi_clk,
  input  logic                         axi_rstn,
  input  logic [G_BASE_ADDR_WIDTH-1:0] local_addr,
  input  logic [31:0]                  local_wr_data,
  input  logic                         local_wr,
  output logic [31:0]                  local_rd_data,
  output logic [G_NUM_LEDS-1:0]        led_out
);
  localparam logic [31:0] C_ID = 32'h4C454430;

  logic                         r_en;
  logic                         r_inv;
  logic [15:0]                  r_prescale;
  logic [15:0]                  r_presc_cnt;
  logic [7:0]                   r_pwm_cnt;
  logic [15:0]                  r_frame_cnt;
  logic [31:0]                  r_rd_data;

  logic                         w_hi;
  logic [5:0]                   w_word;
  logic                         w_wr_ok;
  logic                         w_tick;
  logic                         w_wrap;
  logic                         w_load;
  logic [31:0]                  w_rd;
  logic [G_NUM_LEDS-1:0][7:0]   w_duty;
  logic                         w_unused_bits;

  assign w_hi    = |(local_addr >> 8);
  assign w_word  = 6'(local_addr >> 2);
  assign w_wr_ok = local_wr & ~w_hi;
  assign w_tick  = r_en && (r_presc_cnt == r_prescale);
  assign w_wrap  = w_tick && (r_pwm_cnt == 8'd254);
  assign w_load  = ~r_en | w_wrap;
  assign w_unused_bits = ^local_wr_data[31:16];

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_en        <= 1'b0;
      r_inv       <= 1'b0;
      r_prescale  <= '0;
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_frame_cnt <= '0;
      r_rd_data   <= '0;
    end else begin
      if (w_wr_ok && w_word == 6'd0) begin
        r_en  <= local_wr_data[0];
        r_inv <= local_wr_data[1];
      end
      if (w_wr_ok && w_word == 6'd1) r_prescale <= local_wr_data[15:0];

      // A prescaler lowered below the running count rolls through 0xFFFF.
      if (!r_en) begin
        r_presc_cnt <= '0;
        r_pwm_cnt   <= '0;
      end else begin
        r_presc_cnt <= w_tick ? 16'd0 : r_presc_cnt + 16'd1;
        if (w_tick) r_pwm_cnt <= (r_pwm_cnt == 8'd254) ? 8'd0 : r_pwm_cnt + 8'd1;
        if (w_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_rd_data <= w_rd;
    end
  end

  always_comb begin
    w_rd = '0;
    if (!w_hi) begin
      case (w_word)
        6'd0: w_rd = {30'b0, r_inv, r_en};
        6'd1: w_rd = {16'b0, r_prescale};
        6'd2: w_rd = {r_frame_cnt, 7'b0, r_en, r_pwm_cnt};
        6'd3: w_rd = C_ID;
        default: begin
          for (int i = 0; i < G_NUM_LEDS; i++)
            if (w_word == 6'(i + 4)) w_rd = {24'b0, w_duty[i]};
        end
      endcase
    end
  end

  for (genvar g = 0; g < G_NUM_LEDS; g++) begin : g_chan
    led_pwm_chan u_chan (
      .axi_clk   (axi_clk),
      .axi_rstn  (axi_rstn),
      .i_wr      (w_wr_ok && (w_word == 6'(g + 4))),
      .i_wr_data (local_wr_data[7:0]),
      .i_load    (w_load),
      .i_en      (r_en),
      .i_inv     (r_inv),
      .i_pwm_cnt (r_pwm_cnt),
      .o_duty    (w_duty[g]),
      .o_led     (led_out[g])
    );
  end

  assign local_rd_data = r_rd_data;
endmodule

// File: tb/tb_led_pwm_regs.sv
// Self-checking bench for led_pwm_regs: register map model plus PWM duty,
// shadowing, polarity and reset behaviour measured from led_out waveforms.

module tb_led_pwm_regs;
  localparam int N  = 8;
  localparam int AW = 13;
  localparam logic [31:0] ID = 32'h4C454430;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          wr = 1'b0;
  logic [31:0]   rdata;
  logic [N-1:0]  led;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_en, m_inv;
  logic [15:0] m_presc;
  logic [7:0]  m_duty [N];

  // led_out[0] run-length monitor
  logic  mon_on = 1'b0;
  logic  mon_val;
  int    mon_len;
  int    run_len [$];
  logic  run_val [$];

  always #5 clk = ~clk;

  led_pwm_regs #(.G_NUM_LEDS(N), .G_BASE_ADDR_WIDTH(AW)) dut (
    .axi_clk       (clk),
    .axi_rstn      (rstn),
    .local_addr    (addr),
    .local_wr_data (wdata),
    .local_wr      (wr),
    .local_rd_data (rdata),
    .led_out       (led)
  );

  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_len == 0) begin
        mon_val = led[0];
        mon_len = 1;
      end else if (led[0] === mon_val) begin
        mon_len++;
      end else begin
        run_len.push_back(mon_len);
        run_val.push_back(mon_val);
        mon_val = led[0];
        mon_len = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    m_en = 1'b0; m_inv = 1'b0; m_presc = '0;
    for (int i = 0; i < N; i++) m_duty[i] = '0;
  endfunction

  function automatic void m_write(input logic [AW-1:0] a, input logic [31:0] d);
    int w;
    if ((a >> 8) != 0) return;
    w = int'(a[7:2]);
    case (w)
      0: begin m_en = d[0]; m_inv = d[1]; end
      1: m_presc = d[15:0];
      2, 3: ;
      default: if (w - 4 < N) m_duty[w-4] = d[7:0];
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a, input logic [15:0] frame,
                                         input logic [7:0] pwm);
    int w;
    if ((a >> 8) != 0) return 32'h0;
    w = int'(a[7:2]);
    case (w)
      0: return {30'b0, m_inv, m_en};
      1: return {16'b0, m_presc};
      2: return {frame, 7'b0, m_en, pwm};
      3: return ID;
      default: return (w - 4 < N) ? {24'b0, m_duty[w-4]} : 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] rand_duty();
    case ($urandom_range(0, 4))
      0: return 8'd0;
      1: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    m_write(a, d);
  endtask

  task automatic rd_reg(input logic [AW-1:0] a, output logic [31:0] v);
    addr = a;
    tick();
    v = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [AW-1:0] al [6];
    logic [31:0]   ev [6];
    al = '{13'h000, 13'h004, 13'h008, 13'h00C, 13'h010, 13'h3FC};
    ev = '{32'h0, 32'h0, 32'h0, ID, 32'h0, 32'h0};
    rstn = 1'b0;
    tick(); tick();
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rdata); end
    total++; if (led !== '0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
    rstn = 1'b1;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      rd_reg(al[i], v);
      total++;
      if (v !== ev[i]) begin bad++; $display("FAIL reset_read addr=%h got=%h exp=%h", al[i], v, ev[i]); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v, d;
    logic [AW-1:0] a, ra;
    addr = 13'h010; wr = 1'b1;
    wdata = 32'h11; tick();
    wdata = 32'h22; tick();
    wdata = 32'hAB; tick();
    wr = 1'b0; m_duty[0] = 8'hAB;
    rd_reg(13'h010, v);
    total++; if (v !== 32'hAB) begin bad++; $display("FAIL held_write got=%h exp=ab", v); end
    wr_reg(13'h008, 32'hFFFFFFFF);
    wr_reg(13'h200, 32'hFFFFFFFF);
    rd_reg(13'h008, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL status_ro got=%h exp=0", v); end
    rd_reg(13'h200, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", v); end

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: a = 13'h000;
        1: a = 13'h004;
        2: a = 13'h008;
        3: a = 13'h00C;
        4: a = 13'(16 + 4 * $urandom_range(0, N + 3));
        default: a = 13'($urandom);
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      if ((a >> 8) == 0 && a[7:2] == 6'd0) d[0] = 1'b0;
      wr_reg(a, d);
      ra = ($urandom_range(0, 1) == 0) ? a : 13'($urandom_range(0, 16 + 4 * (N + 2)));
      rd_reg(ra, v);
      total++;
      if (v !== m_read(ra, 16'h0, 8'h0)) begin
        bad++; $display("FAIL rand_rw addr=%h got=%h exp=%h", ra, v, m_read(ra, 16'h0, 8'h0));
      end
      total++;
      if (led !== {N{m_inv}}) begin bad++; $display("FAIL idle_led got=%h exp=%h", led, {N{m_inv}}); end
    end
    wr_reg(13'h000, 32'h0);
  endtask

  task automatic test_enable_start();
    int p;
    p = $urandom_range(0, 5);
    wr_reg(13'h004, 32'(p));
    wr_reg(13'h000, 32'h1);
    addr = 13'h008;
    repeat (p + 1) tick();
    total++;
    if (rdata[8:0] !== 9'h100) begin bad++; $display("FAIL first_tick_pre p=%0d got=%h exp=100", p, rdata[8:0]); end
    tick();
    total++;
    if (rdata[8:0] !== 9'h101) begin bad++; $display("FAIL first_tick p=%0d got=%h exp=101", p, rdata[8:0]); end
    wr_reg(13'h000, 32'h0);
  endtask

  task automatic test_duty_pattern();
    int p, len;
    int hi [N];
    logic [31:0] r0;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 0 : $urandom_range(0, 3);
      wr_reg(13'h004, 32'(p));
      for (int i = 0; i < N; i++) wr_reg(13'(16 + 4 * i), {24'($urandom), rand_duty()});
      if (it == 0) begin
        wr_reg(13'h010, 32'd64);
        wr_reg(13'h014, 32'd0);
        wr_reg(13'h018, 32'd255);
      end
      wr_reg(13'h000, 32'h1);
      repeat (3) tick();
      addr = 13'h008;
      tick();
      r0 = rdata;
      len = 255 * (p + 1);
      for (int i = 0; i < N; i++) hi[i] = 0;
      for (int c = 0; c < len; c++) begin
        tick();
        for (int i = 0; i < N; i++) if (led[i]) hi[i]++;
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (hi[i] != int'(m_duty[i]) * (p + 1)) begin
          bad++; $display("FAIL duty_high ch=%0d p=%0d got=%0d exp=%0d", i, p, hi[i], int'(m_duty[i]) * (p + 1));
        end
      end
      total++;
      if (16'(rdata[31:16] - r0[31:16]) !== 16'd1) begin
        bad++; $display("FAIL frame_inc got=%0d exp=1", 16'(rdata[31:16] - r0[31:16]));
      end
      wr_reg(13'h000, 32'h0);
    end
  endtask

  task automatic test_shadow();
    int to;
    int exp_len [4];
    logic exp_val [4];
    exp_len = '{40, 980, 800, 220};
    exp_val = '{1'b1, 1'b0, 1'b1, 1'b0};
    wr_reg(13'h004, 32'd3);
    wr_reg(13'h010, 32'd10);
    run_len.delete(); run_val.delete();
    mon_len = 0; mon_on = 1'b1;
    wr_reg(13'h000, 32'h1);
    to = 0;
    while (run_len.size() < 2 && to < 3000) begin tick(); to++; end
    if (run_len.size() < 2) begin
      total++; bad++; $display("FAIL shadow_wait1 got=%0d runs exp=2", run_len.size());
    end else begin
      repeat ($urandom_range(100, 800)) tick();
      wr_reg(13'h010, 32'd200);
      to = 0;
      while (run_len.size() < 5 && to < 4000) begin tick(); to++; end
      if (run_len.size() < 5) begin
        total++; bad++; $display("FAIL shadow_wait2 got=%0d runs exp=5", run_len.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          total++;
          if (run_val[k+1] !== exp_val[k] || run_len[k+1] != exp_len[k]) begin
            bad++; $display("FAIL shadow_run k=%0d got=%b/%0d exp=%b/%0d",
                            k, run_val[k+1], run_len[k+1], exp_val[k], exp_len[k]);
          end
        end
      end
    end
    mon_on = 1'b0;
    wr_reg(13'h000, 32'h0);
  endtask

  task automatic test_inv();
    int lo [N];
    wr_reg(13'h000, 32'h2);
    tick();
    total++; if (led !== '1) begin bad++; $display("FAIL inv_idle got=%h exp=%h", led, {N{1'b1}}); end
    wr_reg(13'h004, 32'h0);
    for (int i = 0; i < N; i++) wr_reg(13'(16 + 4 * i), {24'h0, rand_duty()});
    wr_reg(13'h01C, 32'd128);
    wr_reg(13'h000, 32'h3);
    repeat (3) tick();
    for (int i = 0; i < N; i++) lo[i] = 0;
    for (int c = 0; c < 255; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (!led[i]) lo[i]++;
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (lo[i] != int'(m_duty[i])) begin bad++; $display("FAIL inv_low ch=%0d got=%0d exp=%0d", i, lo[i], m_duty[i]); end
    end
    wr_reg(13'h000, 32'h2);
    addr = 13'h008;
    tick();
    total++; if (led !== '1) begin bad++; $display("FAIL inv_disable got=%h exp=%h", led, {N{1'b1}}); end
    tick();
    total++; if (rdata[8:0] !== 9'h0) begin bad++; $display("FAIL disable_cnt got=%h exp=0", rdata[8:0]); end
    wr_reg(13'h000, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [AW-1:0] a;
    wr_reg(13'h004, 32'($urandom_range(0, 3)));
    for (int i = 0; i < N; i++) wr_reg(13'(16 + 4 * i), {24'h0, rand_duty()});
    wr_reg(13'h000, 32'($urandom_range(0, 1) * 2 + 1));
    addr = 13'h008;
    repeat ($urandom_range(50, 500)) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_reset();
    total++; if (led !== '0) begin bad++; $display("FAIL rst_mid_led got=%h exp=0", led); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_rd got=%h exp=0", rdata); end
    for (int k = 0; k < N + 3; k++) begin
      a = 13'(4 * k);
      if (k == 3) continue;
      rd_reg(a, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rst_mid_reg addr=%h got=%h exp=0", a, v); end
      total++;
      if (led !== '0) begin bad++; $display("FAIL rst_mid_pulse got=%h exp=0", led); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_regs();
    test_enable_start();
    test_duty_pattern();
    test_shadow();
    test_inv();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
